vsc8541_smi_responder: RTL and testbench

VSC8541_SMI_RESPONDER -- requirements
Module: vsc8541_smi_responder

---
 rtl/vsc8541_smi_pkg.sv | 31 +++
 rtl/vsc8541_smi_sync.sv | 27 ++
 rtl/vsc8541_smi.sv | 203 ++++++++++++++++++++
 tb/tb_vsc8541_smi_responder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/vsc8541_smi_pkg.sv
// Shared types and constants for the VSC8541-style MDIO/SMI register responder.
package vsc8541_smi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_TA,
    S_RDATA,
    S_WDATA
  } smi_state_e;

  localparam logic [1:0] OP_READ    = 2'b10;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] ST_PATTERN = 2'b01;

  localparam int PHYAD_W = 5;
  localparam int REGAD_W = 5;
  localparam int DATA_W  = 16;

  typedef struct packed {
    smi_state_e  state;
    logic [4:0]  bit_cnt;
    logic        mdc;
    logic        mdio;
    logic        mdio_rise;
  } smi_dbg_t;

endpackage

// File: rtl/vsc8541_smi_sync.sv
// Two-flop synchronizer with rising-edge detect; flops idle high like the MDC/MDIO lines.
module vsc8541_smi_sync (
  input  logic clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= i_async;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign o_level = sync_q;
  assign o_rise  = sync_q & ~prev_q;

endmodule

// File: rtl/vsc8541_smi.sv
// Clause-22 MDIO responder: decodes frames on MDC rising edges, issues register
// read/write strobes and drives read data back onto MDIO.
//
// Handshake: o_rd_en is a one-clk request; i_rd_data must be valid in the clk
// after it and is captured at that clk's end. o_wr_en is a one-clk strobe with
// o_wr_data/o_reg_addr stable during it. There is no back-pressure.
module vsc8541_smi_responder
  import vsc8541_smi_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR     = 5'd0,
  parameter int         PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        i_reset,
  input  logic        i_mdc,
  input  logic        i_mdio,
  output logic        o_mdio,
  output logic        o_mdio_oe,
  output logic [4:0]  o_reg_addr,
  output logic        o_rd_en,
  input  logic [15:0] i_rd_data,
  output logic        o_wr_en,
  output logic [15:0] o_wr_data,
  output smi_dbg_t    o_dbg
);

  localparam int ONES_W = $clog2(PREAMBLE_LEN + 1);
  localparam logic [ONES_W-1:0] ONES_MAX = ONES_W'(PREAMBLE_LEN);

  logic mdc_level, mdc_rise, mdio_s, mdio_rise;

  vsc8541_smi_sync u_sync_mdc (
    .clk(clk), .i_reset(i_reset), .i_async(i_mdc), .o_level(mdc_level), .o_rise(mdc_rise)
  );
  vsc8541_smi_sync u_sync_mdio (
    .clk(clk), .i_reset(i_reset), .i_async(i_mdio), .o_level(mdio_s), .o_rise(mdio_rise)
  );

  smi_state_e         state_q, state_d;
  logic [ONES_W-1:0]  ones_q, ones_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [3:0]         field_q, field_d;
  logic               is_read_q, is_read_d, match_q, match_d, load_q, load_d;
  logic [15:0]        shift_q, shift_d, wr_data_q, wr_data_d;
  logic               mdio_q, mdio_d, oe_q, oe_d, rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [4:0]         reg_addr_q, reg_addr_d;
  logic [4:0]         field_next;
  logic [1:0]         op_bits;

  // Address and opcode fields share one shifter; the 5th sample completes a field.
  assign field_next = {field_q, mdio_s};
  assign op_bits    = {field_q[0], mdio_s};

  always_comb begin
    state_d    = state_q;
    ones_d     = ones_q;
    cnt_d      = cnt_q;
    field_d    = field_q;
    is_read_d  = is_read_q;
    match_d    = match_q;
    load_d     = rd_en_q;
    shift_d    = load_q ? i_rd_data : shift_q;
    wr_data_d  = wr_data_q;
    mdio_d     = mdio_q;
    oe_d       = oe_q;
    rd_en_d    = 1'b0;
    wr_en_d    = 1'b0;
    reg_addr_d = reg_addr_q;
    if (mdc_rise) begin
      case (state_q)
        S_IDLE: begin
          if (mdio_s != ST_PATTERN[1]) begin
            if (ones_q != ONES_MAX) ones_d = ones_q + ONES_W'(1);
          end else begin
            ones_d = '0;
            if (ones_q >= ONES_MAX) state_d = S_START;
          end
        end
        S_START: begin
          cnt_d   = '0;
          state_d = (mdio_s == ST_PATTERN[0]) ? S_OP : S_IDLE;
        end
        S_OP: begin
          field_d = field_next[3:0];
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'd1) begin
            cnt_d     = '0;
            is_read_d = (op_bits == OP_READ);
            state_d   = (op_bits == OP_READ || op_bits == OP_WRITE) ? S_PHYAD : S_IDLE;
          end
        end
        S_PHYAD: begin
          field_d = field_next[3:0];
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'(PHYAD_W - 1)) begin
            cnt_d   = '0;
            match_d = (field_next == PHY_ADDR);
            state_d = S_REGAD;
          end
        end
        S_REGAD: begin
          field_d = field_next[3:0];
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'(REGAD_W - 1)) begin
            cnt_d      = '0;
            reg_addr_d = field_next;
            rd_en_d    = is_read_q & match_q;
            state_d    = S_TA;
          end
        end
        S_TA: begin
          if (is_read_q) begin
            cnt_d = 5'd1;
            if (cnt_q == 5'd0) begin
              oe_d   = match_q;
              mdio_d = ~match_q;
            end else begin
              state_d = S_RDATA;
              mdio_d  = match_q ? shift_q[15] : 1'b1;
              shift_d = {shift_q[14:0], 1'b0};
            end
          end else if (cnt_q == 5'd0) begin
            cnt_d   = 5'd1;
            state_d = mdio_s ? S_TA : S_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = mdio_s ? S_IDLE : S_WDATA;
          end
        end
        S_RDATA: begin
          // cnt_q counts bits already on the wire; the edge after D0 ends the frame.
          if (cnt_q == 5'(DATA_W)) begin
            oe_d    = 1'b0;
            mdio_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d   = cnt_q + 5'd1;
            mdio_d  = match_q ? shift_q[15] : 1'b1;
            shift_d = {shift_q[14:0], 1'b0};
          end
        end
        S_WDATA: begin
          shift_d = {shift_q[14:0], mdio_s};
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'(DATA_W - 1)) begin
            cnt_d   = '0;
            state_d = S_IDLE;
            if (match_q) begin
              wr_en_d   = 1'b1;
              wr_data_d = {shift_q[14:0], mdio_s};
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (state_d == S_IDLE && state_q != S_IDLE) ones_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      ones_q     <= '0;
      cnt_q      <= '0;
      field_q    <= '0;
      is_read_q  <= 1'b0;
      match_q    <= 1'b0;
      load_q     <= 1'b0;
      shift_q    <= '0;
      wr_data_q  <= '0;
      mdio_q     <= 1'b1;
      oe_q       <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      reg_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      ones_q     <= ones_d;
      cnt_q      <= cnt_d;
      field_q    <= field_d;
      is_read_q  <= is_read_d;
      match_q    <= match_d;
      load_q     <= load_d;
      shift_q    <= shift_d;
      wr_data_q  <= wr_data_d;
      mdio_q     <= mdio_d;
      oe_q       <= oe_d;
      rd_en_q    <= rd_en_d;
      wr_en_q    <= wr_en_d;
      reg_addr_q <= reg_addr_d;
    end
  end

  assign o_mdio     = mdio_q;
  assign o_mdio_oe  = oe_q;
  assign o_rd_en    = rd_en_q;
  assign o_wr_en    = wr_en_q;
  assign o_wr_data  = wr_data_q;
  assign o_reg_addr = reg_addr_q;
  assign o_dbg      = '{state: state_q, bit_cnt: cnt_q, mdc: mdc_level,
                        mdio: mdio_s, mdio_rise: mdio_rise};

endmodule

// File: tb/tb_vsc8541_smi_responder.sv
// Station-side bench for vsc8541_smi_responder: directed frame table, hand-written
// abort/reset sequences and randomized frames checked against a frame-level model.
module tb_vsc8541_smi_responder;
  import vsc8541_smi_pkg::*;

  localparam int HALF = 4;
  localparam logic [4:0] DUT_PHY = 5'd0;
  localparam int DUT_PRE = 32;

  logic        clk = 1'b0;
  logic        i_reset, i_mdc, st_val, st_drv;
  logic        mdio_bus, o_mdio, o_mdio_oe, o_rd_en, o_wr_en;
  logic [4:0]  o_reg_addr;
  logic [15:0] i_rd_data, o_wr_data;
  smi_dbg_t    dbg;

  always #5 clk = ~clk;

  // Shared line: responder has priority, else the station, else the pull-up.
  assign mdio_bus = o_mdio_oe ? o_mdio : (st_drv ? st_val : 1'b1);

  vsc8541_smi_responder #(.PHY_ADDR(DUT_PHY), .PREAMBLE_LEN(DUT_PRE)) dut (
    .clk(clk), .i_reset(i_reset), .i_mdc(i_mdc), .i_mdio(mdio_bus),
    .o_mdio(o_mdio), .o_mdio_oe(o_mdio_oe), .o_reg_addr(o_reg_addr),
    .o_rd_en(o_rd_en), .i_rd_data(i_rd_data), .o_wr_en(o_wr_en),
    .o_wr_data(o_wr_data), .o_dbg(dbg)
  );

  typedef struct {
    int          pre;
    logic [1:0]  op;
    logic [4:0]  phy;
    logic [4:0]  regad;
    logic [1:0]  ta;
    logic [15:0] data;
    logic        exp_rd;
    logic        exp_wr;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: strobe/oe accounting and a register file answering one clk after o_rd_en.
  int          rd_cycles = 0, wr_cycles = 0, oe_cycles = 0;
  logic [4:0]  rd_addr_seen = '0, wr_addr_seen = '0;
  logic [15:0] wr_data_seen = '0, rd_value = '0;
  logic        rd_en_prev = 1'b0;

  always @(negedge clk) begin
    if (o_rd_en) begin rd_cycles++; rd_addr_seen = o_reg_addr; end
    if (o_wr_en) begin wr_cycles++; wr_addr_seen = o_reg_addr; wr_data_seen = o_wr_data; end
    if (o_mdio_oe) oe_cycles++;
    i_rd_data  = rd_en_prev ? rd_value : 16'($urandom);
    rd_en_prev = o_rd_en;
  end

  logic [15:0] rbits;
  logic        ta2_bus, ta2_oe, pre_oe, post_oe;

  // One MDC period; the station samples the line just before raising MDC.
  task automatic send_bit(input logic v, input logic drv, output logic s_bus, output logic s_oe);
    st_val = v;
    st_drv = drv;
    i_mdc  = 1'b0;
    repeat (HALF) @(negedge clk);
    s_bus = mdio_bus;
    s_oe  = o_mdio_oe;
    i_mdc = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  // Returns early (before data bit rst_at) when rst_at >= 0 on a read.
  task automatic run_frame(input vec_t f, input int rst_at, input logic sep);
    logic b, o;
    logic [13:0] hdr;
    pre_oe  = 1'b0;
    post_oe = 1'b0;
    rbits   = '0;
    ta2_bus = 1'b1;
    ta2_oe  = 1'b0;
    rd_value = f.data;
    for (int i = 0; i < f.pre; i++) begin send_bit(1'b1, 1'b1, b, o); pre_oe |= o; end
    hdr = {2'b01, f.op, f.phy, f.regad};
    for (int i = 13; i >= 0; i--) begin send_bit(hdr[i], 1'b1, b, o); pre_oe |= o; end
    if (f.op == OP_READ) begin
      send_bit(1'b1, 1'b0, b, o);
      pre_oe |= o;
      send_bit(1'b1, 1'b0, ta2_bus, ta2_oe);
      for (int i = 15; i >= 0; i--) begin
        if (i == rst_at) return;
        send_bit(1'b1, 1'b0, b, o);
        rbits[i] = b;
      end
    end else begin
      send_bit(f.ta[1], 1'b1, b, o); pre_oe |= o;
      send_bit(f.ta[0], 1'b1, b, o); pre_oe |= o;
      for (int i = 15; i >= 0; i--) begin send_bit(f.data[i], 1'b1, b, o); pre_oe |= o; end
    end
    if (sep) send_bit(1'b0, 1'b1, b, post_oe);
  endtask

  task automatic do_frame(input vec_t f, input string tag, input logic sep);
    int rd0, wr0, oe0;
    rd0 = rd_cycles; wr0 = wr_cycles; oe0 = oe_cycles;
    run_frame(f, -1, sep);
    check({tag, " rd_en cycles"}, 32'(rd_cycles - rd0), {31'd0, f.exp_rd});
    check({tag, " wr_en cycles"}, 32'(wr_cycles - wr0), {31'd0, f.exp_wr});
    check({tag, " oe before TA2"}, {31'd0, pre_oe}, 32'd0);
    if (sep) check({tag, " oe after frame"}, {31'd0, post_oe}, 32'd0);
    if (f.exp_rd) begin
      check({tag, " rd addr"}, {27'd0, rd_addr_seen}, {27'd0, f.regad});
      check({tag, " TA2 oe"}, {31'd0, ta2_oe}, 32'd1);
      check({tag, " TA2 level"}, {31'd0, ta2_bus}, 32'd0);
      check({tag, " read bits"}, {16'd0, rbits}, {16'd0, f.data});
    end else begin
      check({tag, " oe cycles"}, 32'(oe_cycles - oe0), 32'd0);
    end
    if (f.exp_wr) begin
      check({tag, " wr addr"}, {27'd0, wr_addr_seen}, {27'd0, f.regad});
      check({tag, " wr data"}, {16'd0, wr_data_seen}, {16'd0, f.data});
    end
  endtask

  // Frame-level reference: accepted iff long enough preamble, our address,
  // a legal opcode and, for writes, the 10 turnaround.
  function automatic vec_t model(input vec_t f);
    vec_t r;
    logic ok;
    r  = f;
    ok = (f.pre >= DUT_PRE) && (f.phy == DUT_PHY);
    r.exp_rd = ok && (f.op == 2'b10);
    r.exp_wr = ok && (f.op == 2'b01) && (f.ta == 2'b10);
    return r;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, " oe"}, {31'd0, o_mdio_oe}, 32'd0);
    check({tag, " mdio"}, {31'd0, o_mdio}, 32'd1);
    check({tag, " rd_en"}, {31'd0, o_rd_en}, 32'd0);
    check({tag, " wr_en"}, {31'd0, o_wr_en}, 32'd0);
    check({tag, " reg_addr"}, {27'd0, o_reg_addr}, 32'd0);
    check({tag, " wr_data"}, {16'd0, o_wr_data}, 32'd0);
    check({tag, " state"}, {29'd0, dbg.state}, {29'd0, S_IDLE});
  endtask

  vec_t tbl[12];
  vec_t v;

  initial begin
    i_reset = 1'b1;
    i_mdc   = 1'b1;
    st_val  = 1'b1;
    st_drv  = 1'b0;
    repeat (4) @(negedge clk);
    check_reset_values("reset");
    i_reset = 1'b0;
    repeat (2) @(negedge clk);

    tbl[0]  = '{32, 2'b10, 5'd0, 5'd3,  2'b00, 16'hA5C3, 1'b1, 1'b0};
    tbl[1]  = '{32, 2'b01, 5'd0, 5'd4,  2'b10, 16'h1234, 1'b0, 1'b1};
    tbl[2]  = '{32, 2'b10, 5'd1, 5'd2,  2'b00, 16'h0F0F, 1'b0, 1'b0};
    tbl[3]  = '{31, 2'b01, 5'd0, 5'd4,  2'b10, 16'h1234, 1'b0, 1'b0};
    tbl[4]  = '{32, 2'b01, 5'd0, 5'd4,  2'b10, 16'h1234, 1'b0, 1'b1};
    tbl[5]  = '{32, 2'b11, 5'd0, 5'd5,  2'b10, 16'h5555, 1'b0, 1'b0};
    tbl[6]  = '{32, 2'b00, 5'd0, 5'd5,  2'b10, 16'hAAAA, 1'b0, 1'b0};
    tbl[7]  = '{32, 2'b01, 5'd0, 5'd6,  2'b01, 16'h6666, 1'b0, 1'b0};
    tbl[8]  = '{32, 2'b01, 5'd0, 5'd6,  2'b00, 16'h7777, 1'b0, 1'b0};
    tbl[9]  = '{32, 2'b10, 5'd0, 5'd31, 2'b00, 16'hFFFF, 1'b1, 1'b0};
    tbl[10] = '{35, 2'b10, 5'd0, 5'd0,  2'b00, 16'h0000, 1'b1, 1'b0};
    tbl[11] = '{40, 2'b01, 5'd0, 5'd31, 2'b10, 16'h0000, 1'b0, 1'b1};
    for (int i = 0; i < 12; i++) do_frame(tbl[i], $sformatf("vec%0d", i), 1'b1);

    // Bad turnaround followed back-to-back by a good write.
    v = '{32, 2'b01, 5'd0, 5'd7, 2'b11, 16'h00FF, 1'b0, 1'b0};
    do_frame(v, "ta11", 1'b0);
    v = '{32, 2'b01, 5'd0, 5'd7, 2'b10, 16'hFFFF, 1'b0, 1'b1};
    do_frame(v, "after_ta11", 1'b1);

    // Reset while D8 is on the wire.
    begin
      int wr0;
      wr0 = wr_cycles;
      v = '{32, 2'b10, 5'd0, 5'd5, 2'b00, 16'h5AF0, 1'b1, 1'b0};
      run_frame(v, 8, 1'b0);
      check("rst D15..D9", {16'd0, rbits[15:9], 9'd0}, {16'd0, v.data[15:9], 9'd0});
      check("rst oe before", {31'd0, o_mdio_oe}, 32'd1);
      i_reset = 1'b1;
      @(negedge clk);
      check("rst oe next clk", {31'd0, o_mdio_oe}, 32'd0);
      repeat (2) @(negedge clk);
      check_reset_values("midreset");
      i_reset = 1'b0;
      st_drv  = 1'b1;
      st_val  = 1'b1;
      repeat (4) @(negedge clk);
      check("rst no write", 32'(wr_cycles - wr0), 32'd0);
      v = '{32, 2'b10, 5'd0, 5'd1, 2'b00, 16'hC3A5, 1'b1, 1'b0};
      do_frame(v, "after_reset", 1'b1);
    end

    for (int n = 0; n < 36; n++) begin
      v.pre   = int'($urandom_range(36, 29));
      v.op    = ($urandom_range(4, 0) == 0) ? 2'($urandom) : ($urandom_range(1, 0) ? 2'b10 : 2'b01);
      v.phy   = ($urandom_range(3, 0) == 0) ? 5'($urandom) : DUT_PHY;
      v.regad = 5'($urandom);
      v.ta    = ($urandom_range(4, 0) == 0) ? 2'($urandom) : 2'b10;
      v.data  = 16'($urandom);
      v = model(v);
      do_frame(v, $sformatf("rand%0d", n), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
